regfile_sb: RTL and testbench

Parametrised multi-read-port register file with write-through bypass and a per-register pending-write scoreboard. It replaces the fixed 2-read/1-write 32×32 register file in the core's decode stage. Decode reads operands and learns in the same cycle whether each operand still awaits an in-flight result. Issue marks a destination busy; writeback stores the result and clears the busy bit.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_scoreboard.sv | 96 +++++++++
 rtl/regfile_sb.sv | 91 +++++++++
 tb/tb_regfile_sb.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and helpers for the regfile_sb register file and its
// pending-write scoreboard.
//   XLEN_DEF   : default data width in bits
//   NREG_DEF   : default number of architectural registers
//   REG_ZERO   : hard-wired zero register address (reads 0, never busy,
//                writes and issues ignored)
//   addr_width : address width needed to index NREG registers
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;

    // Address width for a register count; never narrower than one bit so a
    // degenerate configuration still yields a legal port width.
    function automatic int addr_width(input int nreg);
        if (nreg > 2) begin
            return $clog2(nreg);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Per-register pending-write (busy) tracking for regfile_sb.
// An issue marks its destination busy; a writeback clears it. When both hit
// the same register in one cycle the issue wins, because that instruction is
// the newest producer of the register.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears all busy bits)
//   read_addr   : NRD packed read addresses, port i at [i*AW +: AW]
//   read_busy   : per-port busy flag (combinational)
//   write_ena   : writeback strobe
//   write_addr  : writeback destination
//   issue_ena   : an instruction with a destination issued this cycle
//   issue_addr  : destination of that instruction
//   issue_waw   : issue targets a busy register that is not being cleared now
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int NRD    = 2,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = addr_width(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] read_addr,
    output logic [NRD-1:0]    read_busy,
    input  logic              write_ena,
    input  logic [AW-1:0]     write_addr,
    input  logic              issue_ena,
    input  logic [AW-1:0]     issue_addr,
    output logic              issue_waw
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW-1:0]   w_zero;
    logic            w_wr_valid;
    logic            w_iss_valid;

    assign w_zero      = AW'(REG_ZERO);
    assign w_wr_valid  = write_ena & (write_addr != w_zero);
    assign w_iss_valid = issue_ena & (issue_addr != w_zero);

    // Next busy vector: issue set takes priority over writeback clear; the
    // zero register is forced idle.
    always_comb begin
        w_busy_nxt = '0;
        for (int k = 0; k < NREG; k++) begin
            if (k == REG_ZERO) begin
                w_busy_nxt[k] = 1'b0;
            end else if (w_iss_valid && (issue_addr == AW'(k))) begin
                w_busy_nxt[k] = 1'b1;
            end else if (w_wr_valid && (write_addr == AW'(k))) begin
                w_busy_nxt[k] = 1'b0;
            end else begin
                w_busy_nxt[k] = r_busy[k];
            end
        end
    end

    // Busy vector register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Per-port busy lookup; a same-cycle writeback hides the busy bit only
    // when bypassing is enabled. Same-cycle issues never show up here.
    always_comb begin
        read_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            if (read_addr[p*AW +: AW] == w_zero) begin
                read_busy[p] = 1'b0;
            end else if (BYPASS && w_wr_valid && (write_addr == read_addr[p*AW +: AW])) begin
                read_busy[p] = 1'b0;
            end else begin
                read_busy[p] = r_busy[read_addr[p*AW +: AW]];
            end
        end
    end

    // Write-after-write hazard flag; purely informational.
    always_comb begin
        if (w_iss_valid && r_busy[issue_addr] && !(write_ena && (write_addr == issue_addr))) begin
            issue_waw = 1'b1;
        end else begin
            issue_waw = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Multi-read-port register file with optional write-through bypass and a
// pending-write scoreboard. Decode reads operands and learns in the same
// cycle whether each operand still waits for an in-flight result.
// Parameters: XLEN data width, NREG register count (power of two),
//   NRD read ports (1..4), BYPASS (1 = writeback visible in the same cycle).
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears data and busy)
//   read_addr   : NRD packed read addresses, port i at [i*AW +: AW]
//   read_data   : NRD packed read data, port i at [i*XLEN +: XLEN]
//   read_busy   : per-port pending-write flag
//   write_ena   : writeback strobe
//   write_addr  : writeback destination
//   data_in     : writeback data
//   issue_ena   : instruction with a destination issued this cycle
//   issue_addr  : destination of the issued instruction
//   issue_waw   : issue hits a register that is busy and not being cleared
// -----------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NRD    = 2,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = addr_width(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   read_addr,
    output logic [NRD*XLEN-1:0] read_data,
    output logic [NRD-1:0]      read_busy,
    input  logic                write_ena,
    input  logic [AW-1:0]       write_addr,
    input  logic [XLEN-1:0]     data_in,
    input  logic                issue_ena,
    input  logic [AW-1:0]       issue_addr,
    output logic                issue_waw
);

    logic [XLEN-1:0] r_mem [NREG];
    logic [AW-1:0]   w_zero;
    logic            w_wr_valid;

    assign w_zero     = AW'(REG_ZERO);
    assign w_wr_valid = write_ena & (write_addr != w_zero);

    // Register storage; entry 0 is never written so it holds 0 after reset,
    // and the read mux forces 0 for it regardless.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_wr_valid) begin
            r_mem[write_addr] <= data_in;
        end
    end

    // Read muxes with optional write-through bypass.
    always_comb begin
        read_data = '0;
        for (int p = 0; p < NRD; p++) begin
            if (read_addr[p*AW +: AW] == w_zero) begin
                read_data[p*XLEN +: XLEN] = '0;
            end else if (BYPASS && w_wr_valid && (write_addr == read_addr[p*AW +: AW])) begin
                read_data[p*XLEN +: XLEN] = data_in;
            end else begin
                read_data[p*XLEN +: XLEN] = r_mem[read_addr[p*AW +: AW]];
            end
        end
    end

    regfile_scoreboard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .read_addr  (read_addr),
        .read_busy  (read_busy),
        .write_ena  (write_ena),
        .write_addr (write_addr),
        .issue_ena  (issue_ena),
        .issue_addr (issue_addr),
        .issue_waw  (issue_waw)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Three instances share one clock and reset:
//   u_a : 32x32, 2 read ports, bypass on
//   u_b : 32x32, 2 read ports, bypass off (same inputs as u_a)
//   u_c : 16x32, 4 read ports, bypass on (own inputs, random run)
// Expected values are pushed to exp_q when stimulus is driven and popped at
// the falling edge, where the combinational outputs are compared.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // shared stimulus for u_a / u_b
    logic [9:0]  ra_ab;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] din;
    logic        ie;
    logic [4:0]  ia;
    logic [63:0] rd_a, rd_b;
    logic [1:0]  rb_a, rb_b;
    logic        waw_a, waw_b;
    // stimulus for u_c
    logic [15:0]  ra_c;
    logic         we_c;
    logic [3:0]   wa_c;
    logic [31:0]  din_c;
    logic         ie_c;
    logic [3:0]   ia_c;
    logic [127:0] rd_c;
    logic [3:0]   rb_c;
    logic         waw_c;

    logic [127:0] exp_q[$];
    logic [127:0] e;
    int n_chk  = 0;
    int n_pass = 0;

    regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1'b1)) u_a (
        .clk(clk), .rst(rst), .read_addr(ra_ab), .read_data(rd_a), .read_busy(rb_a),
        .write_ena(we), .write_addr(wa), .data_in(din),
        .issue_ena(ie), .issue_addr(ia), .issue_waw(waw_a));

    regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst(rst), .read_addr(ra_ab), .read_data(rd_b), .read_busy(rb_b),
        .write_ena(we), .write_addr(wa), .data_in(din),
        .issue_ena(ie), .issue_addr(ia), .issue_waw(waw_b));

    regfile_sb #(.XLEN(32), .NREG(16), .NRD(4), .BYPASS(1'b1)) u_c (
        .clk(clk), .rst(rst), .read_addr(ra_c), .read_data(rd_c), .read_busy(rb_c),
        .write_ena(we_c), .write_addr(wa_c), .data_in(din_c),
        .issue_ena(ie_c), .issue_addr(ia_c), .issue_waw(waw_c));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ra_ab = {5'd2, 5'd1};
        exp_q.push_back(128'h0); exp_q.push_back(128'h0);
        exp_q.push_back(128'h0); exp_q.push_back(128'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({64'h0, rd_a} !== e) $display("FAIL reset_data_a got=%h exp=%h", rd_a, e[63:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_a} !== e) $display("FAIL reset_busy_a got=%b exp=%b", rb_a, e[1:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({127'h0, waw_a} !== e) $display("FAIL reset_waw_a got=%b exp=%b", waw_a, e[0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({64'h0, rd_b} !== e) $display("FAIL reset_data_b got=%h exp=%h", rd_b, e[63:0]); else n_pass++;
        cyc();
    endtask

    task automatic test_write_read();
        we = 1'b1; wa = 5'd1; din = 32'h114beef; cyc();
        wa = 5'd2; din = 32'hff1ce11; cyc();
        we = 1'b0; ra_ab = {5'd2, 5'd1};
        exp_q.push_back({64'h0, 32'hff1ce11, 32'h114beef});
        exp_q.push_back(128'h0);
        exp_q.push_back({64'h0, 32'hff1ce11, 32'h114beef});
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({64'h0, rd_a} !== e) $display("FAIL wr_data_a got=%h exp=%h", rd_a, e[63:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_a} !== e) $display("FAIL wr_busy_a got=%b exp=%b", rb_a, e[1:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({64'h0, rd_b} !== e) $display("FAIL wr_data_b got=%h exp=%h", rd_b, e[63:0]); else n_pass++;
        cyc();
    endtask

    task automatic test_zero();
        we = 1'b1; wa = 5'd0; din = 32'h1111111; ra_ab = {5'd0, 5'd0};
        exp_q.push_back(128'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({64'h0, rd_a} !== e) $display("FAIL zero_wr_bypass got=%h exp=%h", rd_a, e[63:0]); else n_pass++;
        cyc();
        we = 1'b0; ie = 1'b1; ia = 5'd0;
        exp_q.push_back(128'h0); exp_q.push_back(128'h0);
        exp_q.push_back(128'h0); exp_q.push_back(128'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({64'h0, rd_a} !== e) $display("FAIL zero_data_a got=%h exp=%h", rd_a, e[63:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({64'h0, rd_b} !== e) $display("FAIL zero_data_b got=%h exp=%h", rd_b, e[63:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_a} !== e) $display("FAIL zero_busy got=%b exp=%b", rb_a, e[1:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({127'h0, waw_a} !== e) $display("FAIL zero_waw got=%b exp=%b", waw_a, e[0]); else n_pass++;
        cyc();
        ie = 1'b0;
        exp_q.push_back(128'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_a} !== e) $display("FAIL zero_busy_after_issue got=%b exp=%b", rb_a, e[1:0]); else n_pass++;
        cyc();
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 5'd5; din = 32'h55555555; cyc();
        din = 32'hdeadbeef; ra_ab = {5'd5, 5'd5};
        exp_q.push_back({64'h0, 32'hdeadbeef, 32'hdeadbeef});
        exp_q.push_back({64'h0, 32'h55555555, 32'h55555555});
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({64'h0, rd_a} !== e) $display("FAIL bypass_on_same got=%h exp=%h", rd_a, e[63:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({64'h0, rd_b} !== e) $display("FAIL bypass_off_same got=%h exp=%h", rd_b, e[63:0]); else n_pass++;
        cyc();
        we = 1'b0;
        exp_q.push_back({64'h0, 32'hdeadbeef, 32'hdeadbeef});
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({64'h0, rd_b} !== e) $display("FAIL bypass_off_next got=%h exp=%h", rd_b, e[63:0]); else n_pass++;
        cyc();
    endtask

    task automatic test_busy();
        ie = 1'b1; ia = 5'd3; ra_ab = {5'd3, 5'd3};
        exp_q.push_back(128'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_a} !== e) $display("FAIL busy_issue_same got=%b exp=%b", rb_a, e[1:0]); else n_pass++;
        cyc();
        // x3 busy now, issuing it again
        exp_q.push_back(128'h3); exp_q.push_back(128'h3); exp_q.push_back(128'h1);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_a} !== e) $display("FAIL busy_set_a got=%b exp=%b", rb_a, e[1:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_b} !== e) $display("FAIL busy_set_b got=%b exp=%b", rb_b, e[1:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({127'h0, waw_a} !== e) $display("FAIL busy_waw got=%b exp=%b", waw_a, e[0]); else n_pass++;
        cyc();
        // write and issue x3 together
        we = 1'b1; wa = 5'd3; din = 32'h33333333;
        exp_q.push_back(128'h0); exp_q.push_back(128'h0); exp_q.push_back(128'h3);
        exp_q.push_back({64'h0, 32'h33333333, 32'h33333333});
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({127'h0, waw_a} !== e) $display("FAIL busy_waw_cleared got=%b exp=%b", waw_a, e[0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_a} !== e) $display("FAIL busy_wi_a got=%b exp=%b", rb_a, e[1:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_b} !== e) $display("FAIL busy_wi_b got=%b exp=%b", rb_b, e[1:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({64'h0, rd_a} !== e) $display("FAIL busy_wi_data got=%h exp=%h", rd_a, e[63:0]); else n_pass++;
        cyc();
        we = 1'b0; ie = 1'b0;
        exp_q.push_back(128'h3); exp_q.push_back(128'h3);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_a} !== e) $display("FAIL busy_new_producer_a got=%b exp=%b", rb_a, e[1:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_b} !== e) $display("FAIL busy_new_producer_b got=%b exp=%b", rb_b, e[1:0]); else n_pass++;
        cyc();
        we = 1'b1; din = 32'h34343434;
        exp_q.push_back(128'h0); exp_q.push_back(128'h3);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_a} !== e) $display("FAIL busy_clr_same_a got=%b exp=%b", rb_a, e[1:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_b} !== e) $display("FAIL busy_clr_same_b got=%b exp=%b", rb_b, e[1:0]); else n_pass++;
        cyc();
        we = 1'b0;
        exp_q.push_back(128'h0); exp_q.push_back(128'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_a} !== e) $display("FAIL busy_clr_next_a got=%b exp=%b", rb_a, e[1:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_b} !== e) $display("FAIL busy_clr_next_b got=%b exp=%b", rb_b, e[1:0]); else n_pass++;
        cyc();
    endtask

    task automatic test_reset_mid();
        ie = 1'b1; ia = 5'd4; cyc();
        ia = 5'd6; we = 1'b1; wa = 5'd6; din = 32'h66666666; cyc();
        ie = 1'b0; we = 1'b0; rst = 1'b1; cyc();
        rst = 1'b0; ra_ab = {5'd6, 5'd4};
        exp_q.push_back(128'h0); exp_q.push_back(128'h0);
        exp_q.push_back(128'h0); exp_q.push_back(128'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({64'h0, rd_a} !== e) $display("FAIL rstmid_data_a got=%h exp=%h", rd_a, e[63:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_a} !== e) $display("FAIL rstmid_busy_a got=%b exp=%b", rb_a, e[1:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({64'h0, rd_b} !== e) $display("FAIL rstmid_data_b got=%h exp=%h", rd_b, e[63:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_b} !== e) $display("FAIL rstmid_busy_b got=%b exp=%b", rb_b, e[1:0]); else n_pass++;
        cyc();
        we = 1'b1; wa = 5'd4; din = 32'h12345678; cyc();
        we = 1'b0; ra_ab = {5'd4, 5'd4};
        exp_q.push_back({64'h0, 32'h12345678, 32'h12345678}); exp_q.push_back(128'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if ({64'h0, rd_b} !== e) $display("FAIL rstmid_wr_data got=%h exp=%h", rd_b, e[63:0]); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({126'h0, rb_b} !== e) $display("FAIL rstmid_wr_busy got=%b exp=%b", rb_b, e[1:0]); else n_pass++;
        cyc();
    endtask

    task automatic test_four_port();
        we_c = 1'b1; wa_c = 4'd9; din_c = 32'hcafef00d; ra_c = {4{4'd9}};
        exp_q.push_back({4{32'hcafef00d}}); exp_q.push_back(128'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (rd_c !== e) $display("FAIL four_port_data got=%h exp=%h", rd_c, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if ({124'h0, rb_c} !== e) $display("FAIL four_port_busy got=%b exp=%b", rb_c, e[3:0]); else n_pass++;
        cyc();
        we_c = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0]  m_mem [16];
        logic [15:0]  m_busy;
        logic [127:0] x_rd;
        logic [3:0]   x_rb;
        logic [3:0]   a;
        rst = 1'b1; cyc();
        for (int k = 0; k < 16; k++) m_mem[k] = 32'h0;
        m_busy = 16'h0;
        for (int i = 0; i < 1000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            we_c  = 1'($urandom_range(0, 1));
            wa_c  = 4'($urandom_range(0, 15));
            din_c = $urandom;
            ie_c  = 1'($urandom_range(0, 1));
            ia_c  = 4'($urandom_range(0, 15));
            ra_c  = 16'($urandom);
            x_rd = '0; x_rb = '0;
            for (int p = 0; p < 4; p++) begin
                a = ra_c[p*4 +: 4];
                if (a == 4'd0) begin
                    x_rd[p*32 +: 32] = 32'h0; x_rb[p] = 1'b0;
                end else if (we_c && wa_c == a) begin
                    x_rd[p*32 +: 32] = din_c; x_rb[p] = 1'b0;
                end else begin
                    x_rd[p*32 +: 32] = m_mem[a]; x_rb[p] = m_busy[a];
                end
            end
            exp_q.push_back(x_rd);
            exp_q.push_back({124'h0, x_rb});
            exp_q.push_back({127'h0, ie_c && ia_c != 4'd0 && m_busy[ia_c] && !(we_c && wa_c == ia_c)});
            @(negedge clk);
            e = exp_q.pop_front(); n_chk++;
            if (rd_c !== e) $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, rd_c, e); else n_pass++;
            e = exp_q.pop_front(); n_chk++;
            if ({124'h0, rb_c} !== e) $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, rb_c, e[3:0]); else n_pass++;
            e = exp_q.pop_front(); n_chk++;
            if ({127'h0, waw_c} !== e) $display("FAIL rand_waw cyc=%0d got=%b exp=%b", i, waw_c, e[0]); else n_pass++;
            // reference model update for the coming edge
            if (rst) begin
                for (int k = 0; k < 16; k++) m_mem[k] = 32'h0;
                m_busy = 16'h0;
            end else begin
                if (we_c && wa_c != 4'd0) begin
                    m_mem[wa_c] = din_c; m_busy[wa_c] = 1'b0;
                end
                if (ie_c && ia_c != 4'd0) m_busy[ia_c] = 1'b1;
            end
            cyc();
        end
        rst = 1'b0; we_c = 1'b0; ie_c = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ra_ab = '0; we = 1'b0; wa = '0; din = '0; ie = 1'b0; ia = '0;
        ra_c = '0; we_c = 1'b0; wa_c = '0; din_c = '0; ie_c = 1'b0; ia_c = '0;
        cyc(); cyc();
        test_reset();
        test_write_read();
        test_zero();
        test_bypass();
        test_busy();
        test_reset_mid();
        test_four_port();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
